// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared types and helpers for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // Watchdog width for a given timeout; never narrower than one bit.
  function automatic int wd_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl_if
// Brief    : Hazard-detect inputs and pipeline-register controls.
//            Optional perf counter ports exist only with STALL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1_i;
  logic [REG_IDX_W-1:0] id_rs2_i;
  logic                 id_uses_rs2_i;
  logic                 id_branch_taken_i;
  logic                 ex_memread_i;
  logic [REG_IDX_W-1:0] ex_rd_i;
  logic                 mem_req_i;
  logic                 mem_ack_i;
  logic                 pc_write_o;
  logic                 ifid_write_o;
  logic                 ifid_flush_o;
  logic                 idex_flush_o;
  logic                 front_hold_o;
  logic                 memwb_bubble_o;
  logic                 mem_err_o;
`ifdef STALL_PERF_EN
  logic [CNT_W-1:0]     stall_cycles_o;
  logic [CNT_W-1:0]     flush_count_o;
`endif

  // Hazard controller side.
  modport master (
    input  id_rs1_i, id_rs2_i, id_uses_rs2_i, id_branch_taken_i,
           ex_memread_i, ex_rd_i, mem_req_i, mem_ack_i,
`ifdef STALL_PERF_EN
    output stall_cycles_o, flush_count_o,
`endif
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           front_hold_o, memwb_bubble_o, mem_err_o
  );

  // Pipeline side.
  modport slave (
    output id_rs1_i, id_rs2_i, id_uses_rs2_i, id_branch_taken_i,
           ex_memread_i, ex_rd_i, mem_req_i, mem_ack_i,
`ifdef STALL_PERF_EN
    input  stall_cycles_o, flush_count_o,
`endif
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           front_hold_o, memwb_bubble_o, mem_err_o
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mem_wait_watchdog.sv
// ============================================================================
// Module   : mem_wait_watchdog
// Brief    : Clear/enable counter; tc_o flags the enabled cycle whose
//            increment reaches TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int WD_W    = 6
) (
  input  wire logic clk_i,
  input  wire logic rst_n_i,
  input  wire logic clear_i,
  input  wire logic en_i,
  output logic      tc_o
);

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;

  assign tc_o = en_i && (wd_q == WD_W'(TIMEOUT - 2));

  always_comb begin
    wd_d = wd_q;
    if (clear_i || tc_o) begin
      wd_d = '0;
    end else if (en_i) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush producer for the 5-stage core: load-use, taken
//            branch and data-memory wait with watchdog. Option: STALL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  wire logic              clk_i,
  input  wire logic              rst_n_i,
  pipeline_hazard_ctrl_if.master hz
);

  localparam int WD_W = wd_width(MEM_TIMEOUT);

  hz_state_e state_q, state_d;
  logic      mem_err_q, mem_err_d;
  logic      wd_clr, wd_en, wd_tc;
  logic      mem_stall, load_use;
  logic      pc_write, ifid_write, ifid_flush, idex_flush, front_hold, memwb_bubble;

  mem_wait_watchdog #(
    .TIMEOUT (MEM_TIMEOUT),
    .WD_W    (WD_W)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (wd_clr),
    .en_i    (wd_en),
    .tc_o    (wd_tc)
  );

  assign load_use = hz.ex_memread_i && (hz.ex_rd_i != '0) &&
                    ((hz.ex_rd_i == hz.id_rs1_i) ||
                     (hz.id_uses_rs2_i && (hz.ex_rd_i == hz.id_rs2_i)));

  always_comb begin
    state_d      = state_q;
    mem_err_d    = mem_err_q;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    mem_stall    = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    front_hold   = 1'b0;
    memwb_bubble = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.mem_req_i && !hz.mem_ack_i) begin
          mem_stall = 1'b1;
          wd_clr    = 1'b1;
          state_d   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ack_i) begin
          wd_clr  = 1'b1;
          state_d = RUN;
        end else begin
          mem_stall = 1'b1;
          wd_en     = 1'b1;
          // Hung access: abandon it and let the pipeline move again.
          if (wd_tc) begin
            mem_err_d = 1'b1;
            state_d   = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (mem_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      front_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (hz.id_branch_taken_i) begin
      ifid_flush = 1'b1;
    end

    // Keep the pipeline empty for as long as reset is held.
    if (!rst_n_i) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      front_hold   = 1'b0;
      memwb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RUN;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign hz.pc_write_o     = pc_write;
  assign hz.ifid_write_o   = ifid_write;
  assign hz.ifid_flush_o   = ifid_flush;
  assign hz.idex_flush_o   = idex_flush;
  assign hz.front_hold_o   = front_hold;
  assign hz.memwb_bubble_o = memwb_bubble;
  assign hz.mem_err_o      = mem_err_q;

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ifid_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cycles_o = stall_cnt_q;
  assign hz.flush_count_o  = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed self-checking bench for pipeline_hazard_ctrl
//            (MEM_TIMEOUT=4). Counter checks appear with STALL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;

  // {pc_write, ifid_write, ifid_flush, idex_flush, front_hold, memwb_bubble, mem_err}
  localparam logic [6:0] C_NORM  = 7'b1100000;
  localparam logic [6:0] C_LU    = 7'b0001000;
  localparam logic [6:0] C_BR    = 7'b1110000;
  localparam logic [6:0] C_STALL = 7'b0000110;
  localparam logic [6:0] C_RST   = 7'b0011010;
  localparam logic [6:0] C_ERR   = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .hz      (bus.master)
  );

  function automatic logic [6:0] outs();
    return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_flush_o,
            bus.front_hold_o, bus.memwb_bubble_o, bus.mem_err_o};
  endfunction

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = outs();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge; sampled 1 time unit later.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                       input logic br, input logic memrd, input logic [4:0] exrd,
                       input logic req, input logic ack);
    @(negedge clk);
    bus.id_rs1_i          = rs1;
    bus.id_rs2_i          = rs2;
    bus.id_uses_rs2_i     = uses2;
    bus.id_branch_taken_i = br;
    bus.ex_memread_i      = memrd;
    bus.ex_rd_i           = exrd;
    bus.mem_req_i         = req;
    bus.mem_ack_i         = ack;
    #1;
  endtask

  initial begin
    bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_uses_rs2_i = 1'b0;
    bus.id_branch_taken_i = 1'b0; bus.ex_memread_i = 1'b0; bus.ex_rd_i = '0;
    bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;
    #1;
    chk("reset_outputs", C_RST);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("idle", C_NORM);
`ifdef STALL_PERF_EN
    chk_cnt("stall_cnt_init", bus.stall_cycles_o, '0);
    chk_cnt("flush_cnt_init", bus.flush_count_o, '0);
`endif

    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("load_use_rs1", C_LU);
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
    chk("load_use_cleared", C_NORM);
    drive(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    chk("load_use_rs2", C_LU);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("x0_no_stall", C_NORM);
    drive(5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    chk("rs2_unused_no_stall", C_NORM);

    drive(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("branch_flush", C_BR);
    drive(5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("branch_done", C_NORM);
    drive(5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
    chk("branch_on_load_stalls", C_LU);
    drive(5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("branch_reeval_flush", C_BR);

    drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    chk("mem_wait_1_over_lu", C_STALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("mem_wait_2", C_STALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("mem_wait_3", C_STALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("mem_ack_advance", C_NORM);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("after_ack_run", C_NORM);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("req_ack_same_cycle", C_NORM);

    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      chk($sformatf("timeout_stall_%0d", i), C_STALL);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("timeout_err_run", C_NORM | C_ERR);
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("err_sticky_branch", C_BR | C_ERR);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("err_sticky_req_ack", C_NORM | C_ERR);

    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("pre_reset_wait_1", C_STALL | C_ERR);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("pre_reset_wait_2", C_STALL | C_ERR);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_wait", C_RST);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("reset_held", C_RST);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_run", C_NORM);
`ifdef STALL_PERF_EN
    chk_cnt("stall_cnt_post_reset", bus.stall_cycles_o, '0);
    chk_cnt("flush_cnt_post_reset", bus.flush_count_o, '0);
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_cnt("stall_cnt_one", bus.stall_cycles_o, 16'd1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_cnt("flush_cnt_one", bus.flush_count_o, 16'd1);
`endif
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("post_reset_new_wait", C_STALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("post_reset_ack", C_NORM);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
